// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and ALU select encodings for the MIPS datapath
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W = 4;
  typedef enum logic [SEL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_sel_e;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: picks the freshest value of one source register from EX/MEM, MEM/WB or the held copy
module fwd_unit
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic          exmem_mem_read,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] data
);
  // a load in EX/MEM has no result yet, so it never forwards from there
  always_comb
    data = (exmem_reg_write && !exmem_mem_read && exmem_rd != '0 && exmem_rd == addr) ? exmem_result :
           (memwb_reg_write && memwb_rd != '0 && memwb_rd == addr) ? memwb_result : reg_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with operand forwarding and load-use stall
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW,
  parameter int SW = SEL_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_rs_data,
  input  logic [DW-1:0] i_rt_data,
  input  logic [DW-1:0] i_imm,
  input  logic [AW-1:0] i_rs_addr,
  input  logic [AW-1:0] i_rt_addr,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [SW-1:0] i_alu_sel,
  input  logic          i_alu_src,
  input  logic          i_reg_write,
  input  logic          i_mem_read,
  input  logic          i_mem_write,
  input  logic          i_mem_to_reg,
  input  logic          i_flush,
  input  logic          i_exmem_reg_write,
  input  logic          i_exmem_mem_read,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic [DW-1:0] i_exmem_result,
  input  logic          i_memwb_reg_write,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic [DW-1:0] i_memwb_result,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_op1,
  output logic [DW-1:0] o_op2,
  output logic [SW-1:0] o_sel,
  output logic [DW-1:0] o_store_data,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_reg_write,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic          o_mem_to_reg
);
  logic [DW-1:0] rs_data, rt_data, imm, fwd_rs, fwd_rt;
  logic [AW-1:0] rs_addr, rt_addr;
  logic          alu_src, hazard, accept;
  fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr(rs_addr), .reg_data(rs_data),
    .exmem_reg_write(i_exmem_reg_write), .exmem_mem_read(i_exmem_mem_read),
    .exmem_rd(i_exmem_rd), .exmem_result(i_exmem_result),
    .memwb_reg_write(i_memwb_reg_write), .memwb_rd(i_memwb_rd),
    .memwb_result(i_memwb_result), .data(fwd_rs)
  );
  fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr(rt_addr), .reg_data(rt_data),
    .exmem_reg_write(i_exmem_reg_write), .exmem_mem_read(i_exmem_mem_read),
    .exmem_rd(i_exmem_rd), .exmem_result(i_exmem_result),
    .memwb_reg_write(i_memwb_reg_write), .memwb_rd(i_memwb_rd),
    .memwb_result(i_memwb_result), .data(fwd_rt)
  );
  // rt only matters to a load-use stall when it feeds the ALU or is stored
  always_comb begin
    hazard = o_valid && o_mem_read && o_wr_addr != '0 &&
             (o_wr_addr == i_rs_addr || (o_wr_addr == i_rt_addr && (!i_alu_src || i_mem_write)));
    o_ready = (!o_valid || i_ready) && !hazard;
    accept = i_valid && o_ready;
    o_op1 = fwd_rs;
    o_op2 = alu_src ? imm : fwd_rt;
    o_store_data = fwd_rt;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_valid <= 1'b0;
      rs_data <= '0;
      rt_data <= '0;
      imm <= '0;
      rs_addr <= '0;
      rt_addr <= '0;
      o_wr_addr <= '0;
      o_sel <= '0;
      alu_src <= 1'b0;
      o_reg_write <= 1'b0;
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_to_reg <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_reg_write <= 1'b0;
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_to_reg <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      rs_data <= i_rs_data;
      rt_data <= i_rt_data;
      imm <= i_imm;
      rs_addr <= i_rs_addr;
      rt_addr <= i_rt_addr;
      o_wr_addr <= i_wr_addr;
      o_sel <= i_alu_sel;
      alu_src <= i_alu_src;
      o_reg_write <= i_reg_write;
      o_mem_read <= i_mem_read;
      o_mem_write <= i_mem_write;
      o_mem_to_reg <= i_mem_to_reg;
    end else if (o_valid && !i_ready) begin
      rs_data <= fwd_rs;
      rt_data <= fwd_rt;
    end else begin
      o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus random traffic against a behavioural model
module tb_id_ex_stage;
  import mips_pkg::*;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  logic        i_rst, i_valid, o_ready, i_alu_src, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic        i_flush, i_exmem_reg_write, i_exmem_mem_read, i_memwb_reg_write, o_valid, i_ready;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic [31:0] i_rs_data, i_rt_data, i_imm, i_exmem_result, i_memwb_result;
  logic [31:0] o_op1, o_op2, o_store_data;
  logic [4:0]  i_rs_addr, i_rt_addr, i_wr_addr, i_exmem_rd, i_memwb_rd, o_wr_addr;
  logic [3:0]  i_alu_sel, o_sel;
  int errors = 0, checks = 0;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_wr_addr(i_wr_addr),
    .i_alu_sel(i_alu_sel), .i_alu_src(i_alu_src), .i_reg_write(i_reg_write),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .i_flush(i_flush), .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_mem_read(i_exmem_mem_read),
    .i_exmem_rd(i_exmem_rd), .i_exmem_result(i_exmem_result),
    .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd(i_memwb_rd), .i_memwb_result(i_memwb_result),
    .o_valid(o_valid), .i_ready(i_ready), .o_op1(o_op1), .o_op2(o_op2), .o_sel(o_sel),
    .o_store_data(o_store_data), .o_wr_addr(o_wr_addr), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic v, src, rw, mr, mw, m2r;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0] rs, rt, wr;
    logic [3:0] sel;
  } ent_t;
  ent_t m;
  bit m_ok = 0;

  // newest producer wins; a load still in EX/MEM has nothing to give
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (i_exmem_reg_write && !i_exmem_mem_read && i_exmem_rd == a) return i_exmem_result;
    if (i_memwb_reg_write && i_memwb_rd == a) return i_memwb_result;
    return d;
  endfunction

  function automatic logic exp_ready();
    logic uses_load;
    uses_load = m.v && m.mr && m.wr != 5'd0 &&
                (m.wr == i_rs_addr || (m.wr == i_rt_addr && (!i_alu_src || i_mem_write)));
    return (!m.v || i_ready) && !uses_load;
  endfunction

  task automatic cycle();
    logic [31:0] a, b;
    @(negedge i_clk);
    if (m_ok) begin
      check("m_valid", 32'(o_valid), 32'(m.v));
      check("m_ready", 32'(o_ready), 32'(exp_ready()));
      check("m_op1", o_op1, fwd(m.rs, m.rs_d));
      check("m_op2", o_op2, m.src ? m.imm : fwd(m.rt, m.rt_d));
      check("m_store", o_store_data, fwd(m.rt, m.rt_d));
      check("m_sel", 32'(o_sel), 32'(m.sel));
      check("m_wr", 32'(o_wr_addr), 32'(m.wr));
      check("m_ctl", {28'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg},
            {28'd0, m.rw, m.mr, m.mw, m.m2r});
    end
    if (i_rst) begin
      m = '{default: '0};
      m_ok = 1;
    end else if (i_flush) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
    end else if (i_valid && exp_ready()) begin
      m = '{v: 1'b1, src: i_alu_src, rw: i_reg_write, mr: i_mem_read, mw: i_mem_write,
            m2r: i_mem_to_reg, rs_d: i_rs_data, rt_d: i_rt_data, imm: i_imm,
            rs: i_rs_addr, rt: i_rt_addr, wr: i_wr_addr, sel: i_alu_sel};
    end else if (m.v && !i_ready) begin
      a = fwd(m.rs, m.rs_d);
      b = fwd(m.rt, m.rt_d);
      m.rs_d = a;
      m.rt_d = b;
    end else begin
      m.v = 0;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    {i_rst, i_valid, i_alu_src, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_flush} = '0;
    {i_exmem_reg_write, i_exmem_mem_read, i_memwb_reg_write} = '0;
    {i_rs_data, i_rt_data, i_imm, i_exmem_result, i_memwb_result} = '0;
    {i_rs_addr, i_rt_addr, i_wr_addr, i_exmem_rd, i_memwb_rd} = '0;
    i_alu_sel = '0;
    i_ready = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rs, rt, wr, input logic [31:0] rsd, rtd, input logic [3:0] sel,
                       input logic src, rw, mr, mw);
    i_valid = 1; i_rs_addr = rs; i_rt_addr = rt; i_wr_addr = wr;
    i_rs_data = rsd; i_rt_data = rtd; i_alu_sel = sel;
    i_alu_src = src; i_reg_write = rw; i_mem_read = mr; i_mem_write = mw; i_mem_to_reg = mr;
  endtask

  initial begin
    idle();
    i_rst = 1;
    cycle();
    cycle();
    idle();
    #1;
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_sel", 32'(o_sel), 32'h0);
    check("rst_op1", o_op1, 32'h0);
    check("rst_op2", o_op2, 32'h0);
    issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, ALU_ADD, 0, 1, 0, 0);
    cycle();
    idle();
    #1;
    check("add_valid", 32'(o_valid), 32'h1);
    check("add_sel", 32'(o_sel), 32'h2);
    check("add_op1", o_op1, 32'd5);
    check("add_op2", o_op2, 32'd7);
    i_ready = 0;
    i_exmem_reg_write = 1; i_exmem_rd = 5'd1; i_exmem_result = 32'hAA;
    i_memwb_reg_write = 1; i_memwb_rd = 5'd1; i_memwb_result = 32'hBB;
    #1;
    check("fwd_exmem", o_op1, 32'hAA);
    i_exmem_mem_read = 1;
    #1;
    check("fwd_memwb", o_op1, 32'hBB);
    idle();
    cycle();
    issue(5'd1, 5'd4, 5'd4, 32'd1, 32'd0, ALU_ADD, 1, 1, 1, 0);
    cycle();
    issue(5'd4, 5'd1, 5'd5, 32'd0, 32'd3, ALU_ADD, 0, 1, 0, 0);
    #1;
    check("lu_stall", 32'(o_ready), 32'h0);
    cycle();
    check("lu_bubble", 32'(o_valid), 32'h0);
    check("lu_ready", 32'(o_ready), 32'h1);
    cycle();
    check("lu_accept", 32'(o_valid), 32'h1);
    check("lu_wr", 32'(o_wr_addr), 32'd5);
    idle();
    issue(5'd1, 5'd2, 5'd6, 32'd1, 32'h11, ALU_SUB, 0, 1, 0, 0);
    cycle();
    idle();
    i_ready = 0;
    i_memwb_reg_write = 1; i_memwb_rd = 5'd2; i_memwb_result = 32'h55;
    cycle();
    i_memwb_reg_write = 0; i_memwb_result = 32'h0;
    cycle();
    cycle();
    check("hold_op2", o_op2, 32'h55);
    check("hold_valid", 32'(o_valid), 32'h1);
    idle();
    issue(5'd1, 5'd2, 5'd0, 32'd1, 32'd2, ALU_ADD, 0, 1, 0, 1);
    i_flush = 1;
    cycle();
    idle();
    #1;
    check("flush_valid", 32'(o_valid), 32'h0);
    check("flush_rw", 32'(o_reg_write), 32'h0);
    check("flush_mw", 32'(o_mem_write), 32'h0);
    issue(5'd0, 5'd0, 5'd7, 32'h123, 32'd0, ALU_OR, 0, 1, 0, 0);
    cycle();
    idle();
    i_ready = 0;
    i_exmem_reg_write = 1; i_exmem_rd = 5'd0; i_exmem_result = 32'hFFFF;
    i_memwb_reg_write = 1; i_memwb_rd = 5'd0; i_memwb_result = 32'hFFFF;
    #1;
    check("r0_op1", o_op1, 32'h123);
    idle();
    issue(5'd3, 5'd4, 5'd5, 32'h9, 32'h8, ALU_SLT, 0, 1, 1, 1);
    i_rst = 1;
    i_flush = 1;
    cycle();
    idle();
    #1;
    check("mrst_valid", 32'(o_valid), 32'h0);
    check("mrst_op1", o_op1, 32'h0);
    check("mrst_op2", o_op2, 32'h0);
    check("mrst_store", o_store_data, 32'h0);
    check("mrst_ctl", {24'd0, o_sel, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg}, 32'h0);
    for (int n = 0; n < 500; n++) begin
      i_rst = ($urandom_range(0, 79) == 0);
      i_flush = ($urandom_range(0, 15) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_rs_addr = 5'($urandom_range(0, 3));
      i_rt_addr = 5'($urandom_range(0, 3));
      i_wr_addr = 5'($urandom_range(0, 3));
      i_rs_data = $urandom;
      i_rt_data = $urandom;
      i_imm = $urandom;
      i_alu_sel = 4'($urandom);
      {i_alu_src, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg} = 5'($urandom);
      {i_exmem_reg_write, i_exmem_mem_read, i_memwb_reg_write} = 3'($urandom);
      i_exmem_rd = 5'($urandom_range(0, 3));
      i_memwb_rd = 5'($urandom_range(0, 3));
      i_exmem_result = $urandom;
      i_memwb_result = $urandom;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
